op_process_ctrl: RTL

OP_PROCESS_CTRL -- requirements
Module: op_process_ctrl

---
 rtl/op_process_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/op_process_ctrl.sv
// Operation sequencer for a matrix compute core: validates operand dimensions,
// launches the core, and runs a timed error recovery with a visible countdown.
module op_process_ctrl #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int DIM_W       = 4,
    parameter int MAX_DIM     = 5,
    parameter int CNT_MIN     = 5,
    parameter int CNT_MAX     = 15,
    parameter int CNT_DEFAULT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             confirm_btn,
    input  logic [2:0]       op_code,
    input  logic [DIM_W-1:0] matA_row,
    input  logic [DIM_W-1:0] matA_col,
    input  logic [DIM_W-1:0] matB_row,
    input  logic [DIM_W-1:0] matB_col,
    input  logic             config_en,
    input  logic [3:0]       config_val,
    input  logic             calc_done,
    output logic             calc_start,
    output logic [DIM_W-1:0] res_row,
    output logic [DIM_W-1:0] res_col,
    output logic             busy,
    output logic             error_led,
    output logic [1:0]       err_code,
    output logic [3:0]       cnt_display,
    output logic             sel_reset,
    output logic             done_pulse,
    output logic [2:0]       status_code
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [DIM_W-1:0]  MAX_DIM_V = DIM_W'(MAX_DIM);
    localparam logic [3:0] CNT_MIN_V = 4'(CNT_MIN);
    localparam logic [3:0] CNT_MAX_V = 4'(CNT_MAX);
    localparam logic [3:0] CNT_DEF_V = 4'(CNT_DEFAULT);

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_MUL    = 3'd1;
    localparam logic [2:0] OP_SCALAR = 3'd2;
    localparam logic [2:0] OP_TRANS  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_CALC  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_OP       = 2'd3
    } err_e;

    state_e             state_q, state_d;
    err_e               err_code_q, err_code_d;
    logic [3:0]         setting_q, setting_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [DIM_W-1:0]   res_row_q, res_row_d;
    logic [DIM_W-1:0]   res_col_q, res_col_d;
    logic               calc_start_q, calc_start_d;
    logic               sel_reset_q, sel_reset_d;

    err_e               chk_code;
    logic [DIM_W-1:0]   chk_row, chk_col;
    logic               a_bad, b_bad;
    logic [3:0]         cfg_clamped;
    logic               tick_wrap, timeout;

    function automatic logic dim_bad(input logic [DIM_W-1:0] d);
        return (d == '0) || (d > MAX_DIM_V);
    endfunction

    // Validity and result shape of the operation currently on the inputs.
    always_comb begin
        a_bad    = dim_bad(matA_row) || dim_bad(matA_col);
        b_bad    = dim_bad(matB_row) || dim_bad(matB_col);
        chk_code = ERR_NONE;
        chk_row  = matA_row;
        chk_col  = matA_col;
        case (op_code)
            OP_ADD: begin
                if (a_bad || b_bad)
                    chk_code = ERR_RANGE;
                else if ((matA_row != matB_row) || (matA_col != matB_col))
                    chk_code = ERR_MISMATCH;
            end
            OP_MUL: begin
                chk_col = matB_col;
                if (a_bad || b_bad)
                    chk_code = ERR_RANGE;
                else if (matA_col != matB_row)
                    chk_code = ERR_MISMATCH;
            end
            OP_SCALAR: begin
                if (a_bad)
                    chk_code = ERR_RANGE;
            end
            OP_TRANS: begin
                chk_row = matA_col;
                chk_col = matA_row;
                if (a_bad)
                    chk_code = ERR_RANGE;
            end
            default: chk_code = ERR_OP;
        endcase
    end

    always_comb begin
        if (config_val < CNT_MIN_V)
            cfg_clamped = CNT_MIN_V;
        else if (config_val > CNT_MAX_V)
            cfg_clamped = CNT_MAX_V;
        else
            cfg_clamped = config_val;
    end

    assign tick_wrap = (tick_q == TICK_LAST);
    assign timeout   = tick_wrap && (cnt_q == 4'd1);

    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        err_code_d   = err_code_q;
        setting_d    = setting_q;
        cnt_d        = cnt_q;
        tick_d       = tick_q;
        res_row_d    = res_row_q;
        res_col_d    = res_col_q;
        calc_start_d = 1'b0;
        sel_reset_d  = 1'b0;

        if (config_en)
            setting_d = cfg_clamped;

        case (state_q)
            ST_IDLE: begin
                if (confirm_btn)
                    state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (chk_code != ERR_NONE) begin
                    state_d    = ST_ERROR;
                    err_code_d = chk_code;
                    cnt_d      = setting_q;
                    tick_d     = '0;
                end else begin
                    state_d      = ST_CALC;
                    calc_start_d = 1'b1;
                    res_row_d    = chk_row;
                    res_col_d    = chk_col;
                end
            end
            ST_CALC: begin
                if (calc_done)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERROR: begin
                if (tick_wrap) begin
                    tick_d = '0;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
                // Timeout wins over a coincident confirm.
                if (timeout) begin
                    state_d     = ST_IDLE;
                    sel_reset_d = 1'b1;
                    err_code_d  = ERR_NONE;
                end else if (confirm_btn) begin
                    state_d = ST_CHECK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            err_code_q   <= ERR_NONE;
            setting_q    <= CNT_DEF_V;
            cnt_q        <= '0;
            tick_q       <= '0;
            res_row_q    <= '0;
            res_col_q    <= '0;
            calc_start_q <= 1'b0;
            sel_reset_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_code_q   <= err_code_d;
            setting_q    <= setting_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            res_row_q    <= res_row_d;
            res_col_q    <= res_col_d;
            calc_start_q <= calc_start_d;
            sel_reset_q  <= sel_reset_d;
        end
    end

    assign status_code = state_q;
    assign busy        = (state_q == ST_CHECK) || (state_q == ST_CALC) || (state_q == ST_DONE);
    assign error_led   = (state_q == ST_ERROR);
    assign cnt_display = error_led ? cnt_q : 4'd0;
    assign done_pulse  = (state_q == ST_DONE);
    assign calc_start  = calc_start_q;
    assign sel_reset   = sel_reset_q;
    assign err_code    = err_code_q;
    assign res_row     = res_row_q;
    assign res_col     = res_col_q;

endmodule
